// File: rtl/wb_rom_loader_if.sv
// Wishbone classic bus bundle between the management core (master) and the ROM loader (slave).
interface wb_rom_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_rom_loader.sv
// Wishbone register window that buffers ROM words in a FIFO and drains them to the SoC ROM port.
// Optional: define ROM_LOADER_CHECKSUM_EN for a 16-bit running sum of drained words at 0x10.
module wb_rom_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_rom_loader_if.slave    wbs,
  output logic              rom_valid_o,
  input  logic              rom_ready_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              soc_rst_o,
  output logic              busy_o
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {StIdle, StSend, StFlush} state_e;

  state_e            state_q, state_d;
  logic              ack_q;
  logic [31:0]       dat_q, rdata;
  logic              soc_rst_q, drain_en_q, flush_q, wrap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [EntW-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, load_ptr;
  logic [CntW-1:0]   count_q;
  logic              valid_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] rom_data_q;
  logic              load, pop, clr;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]       csum_q;
`endif

  logic       hit, full, stall, acc, wr, push;
  logic       wr_ctrl, wr_addr, wr_data, wr_stat;
  logic [5:0] offset;

  assign offset  = wbs.wbs_adr_i[7:2];
  assign hit     = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign full    = (count_q == CntW'(FIFO_DEPTH));
  // A full FIFO stalls DATA writes, unless a flush is pending (that push is dropped anyway).
  assign stall   = wbs.wbs_we_i & (offset == 6'h02) & full & ~flush_q;
  assign acc     = hit & ~ack_q & ~stall;
  assign wr      = acc & wbs.wbs_we_i;
  assign wr_ctrl = wr & (offset == 6'h00);
  assign wr_addr = wr & (offset == 6'h01);
  assign wr_data = wr & (offset == 6'h02);
  assign wr_stat = wr & (offset == 6'h03);
  assign push    = wr_data & ~flush_q;

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign rom_valid_o   = valid_q;
  assign rom_addr_o    = rom_addr_q;
  assign rom_data_o    = rom_data_q;
  assign soc_rst_o     = soc_rst_q;
  assign busy_o        = (count_q != '0) | valid_q;

  logic unused_bits;
  assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:DATA_W]};

  always_comb begin
    rdata = '0;
    case (offset)
      6'h00:   rdata = {30'b0, drain_en_q, soc_rst_q};
      6'h01:   rdata = 32'(addr_q);
      6'h03:   rdata = {22'b0, full, wrap_q, 4'(count_q), 3'b0, busy_o};
`ifdef ROM_LOADER_CHECKSUM_EN
      6'h04:   rdata = {16'b0, csum_q};
`endif
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      soc_rst_q  <= 1'b1;
      drain_en_q <= 1'b0;
      flush_q    <= 1'b0;
      wrap_q     <= 1'b0;
      addr_q     <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc & ~wbs.wbs_we_i) ? rdata : '0;
      if (wr_ctrl) begin
        soc_rst_q  <= wbs.wbs_dat_i[0];
        drain_en_q <= wbs.wbs_dat_i[1];
      end
      if (wr_ctrl & wbs.wbs_dat_i[2]) flush_q <= 1'b1;
      else if (clr)                   flush_q <= 1'b0;
      if (wr_addr)      addr_q <= wbs.wbs_dat_i[ADDR_W-1:0];
      else if (wr_data) addr_q <= addr_q + ADDR_W'(1);
      if (wr_data & (&addr_q))              wrap_q <= 1'b1;
      else if (wr_stat & wbs.wbs_dat_i[8]) wrap_q <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {addr_q, wbs.wbs_dat_i[DATA_W-1:0]};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (!flush_q && drain_en_q && count_q != '0) state_d = StSend;
      StSend: begin
        if (rom_ready_i) begin
          if (!flush_q && drain_en_q && count_q > CntW'(1)) state_d = StSend;
          else                                              state_d = StIdle;
        end else if (flush_q) begin
          state_d = StFlush;
        end
      end
      StFlush: if (rom_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    load_ptr = rd_ptr_q;
    case (state_q)
      StIdle: begin
        load = !flush_q && drain_en_q && count_q != '0;
        clr  = flush_q;
      end
      StSend: begin
        pop      = rom_ready_i;
        load     = rom_ready_i && !flush_q && drain_en_q && count_q > CntW'(1);
        clr      = rom_ready_i && flush_q;
        load_ptr = rd_ptr_q + PtrW'(1);
      end
      StFlush: begin
        pop = rom_ready_i;
        clr = rom_ready_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
    end else begin
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
      if (load) begin
        {rom_addr_q, rom_data_q} <= mem_q[load_ptr];
        valid_q                  <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                     csum_q <= '0;
    else if (wr & (offset == 6'h04))  csum_q <= '0;
    else if (valid_q & rom_ready_i)   csum_q <= csum_q + 16'(rom_data_q);
  end
`endif
endmodule

// File: tb/tb_wb_rom_loader.sv
// Directed bench for wb_rom_loader: register access, drain handshake, stall, flush, wrap, reset.
module tb_wb_rom_loader;
  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_valid, rom_ready, soc_rst, busy;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  int          checks = 0;
  int          failures = 0;
  int          cyc_cnt = 0;
  logic [31:0] rd;
  int          ack_c, ack5, pop_cyc, bad, acks;
  bit          done5;
  logic [14:0] beat_addr[$];
  logic [15:0] beat_data[$];
  int          beat_cyc[$];

  wb_rom_loader_if wbs_if ();

  wb_rom_loader #(
    .BASE_ADDR (Base),
    .FIFO_DEPTH(4),
    .ADDR_W    (15),
    .DATA_W    (16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs        (wbs_if),
    .rom_valid_o(rom_valid),
    .rom_ready_i(rom_ready),
    .rom_addr_o (rom_addr),
    .rom_data_o (rom_data),
    .soc_rst_o  (soc_rst),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    if (!rst && rom_valid && rom_ready) begin
      beat_addr.push_back(rom_addr);
      beat_data.push_back(rom_data);
      beat_cyc.push_back(cyc_cnt);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, output logic [31:0] rdat, output int ack_cyc);
    bit acked = 0;
    rdat    = '0;
    ack_cyc = -1;
    wbs_if.wbs_stb_i = 1'b1;
    wbs_if.wbs_cyc_i = 1'b1;
    wbs_if.wbs_we_i  = we;
    wbs_if.wbs_adr_i = adr;
    wbs_if.wbs_dat_i = dat;
    for (int i = 0; i < 64 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (wbs_if.wbs_ack_o) begin
        acked   = 1;
        rdat    = wbs_if.wbs_dat_o;
        ack_cyc = cyc_cnt;
      end
    end
    wbs_if.wbs_stb_i = 1'b0;
    wbs_if.wbs_cyc_i = 1'b0;
    wbs_if.wbs_we_i  = 1'b0;
    if (!acked) check_eq({tag, "_ack"}, 32'(acked), 32'd1);
  endtask

  task automatic wb_write(input string tag, input logic [31:0] off, input logic [31:0] dat);
    logic [31:0] unused_rd;
    int          unused_c;
    wb_xfer(tag, 1'b1, Base + off, dat, unused_rd, unused_c);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] off, output logic [31:0] dat);
    int unused_c;
    wb_xfer(tag, 1'b0, Base + off, 32'h0, dat, unused_c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    beat_addr.delete();
    beat_data.delete();
    beat_cyc.delete();
  endtask

  initial begin
    wbs_if.wbs_stb_i = 1'b0;
    wbs_if.wbs_cyc_i = 1'b0;
    wbs_if.wbs_we_i  = 1'b0;
    wbs_if.wbs_sel_i = 4'hF;
    wbs_if.wbs_dat_i = '0;
    wbs_if.wbs_adr_i = '0;
    rom_ready = 1'b0;
    do_reset();

    // Reset state and decode
    check_eq("rst_soc_rst", 32'(soc_rst), 32'd1);
    check_eq("rst_valid", 32'(rom_valid), 32'd0);
    check_eq("rst_ack", 32'(wbs_if.wbs_ack_o), 32'd0);
    wb_read("rd_ctrl", 32'h00, rd);   check_eq("rst_ctrl", rd, 32'h1);
    wb_read("rd_stat", 32'h0C, rd);   check_eq("rst_status", rd, 32'h0);
    wbs_if.wbs_adr_i = Base + 32'h100;
    wbs_if.wbs_stb_i = 1'b1;
    wbs_if.wbs_cyc_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (wbs_if.wbs_ack_o) acks++;
    end
    wbs_if.wbs_stb_i = 1'b0;
    wbs_if.wbs_cyc_i = 1'b0;
    check_eq("no_ack_outside", 32'(acks), 32'd0);
    wb_read("rd_unmapped", 32'h20, rd); check_eq("unmapped_read", rd, 32'h0);

    // Back-to-back drain of two words
    wb_write("wr_addr", 32'h04, 32'h10);
    wb_write("wr_d0", 32'h08, 32'hFFFF_ABCD);
    wb_write("wr_d1", 32'h08, 32'h1234);
    rom_ready = 1'b1;
    wb_write("wr_ctrl", 32'h00, 32'h3);
    cycles(4);
    check_eq("beats_n", 32'(beat_addr.size()), 32'd2);
    if (beat_addr.size() == 2) begin
      check_eq("beat0_addr", 32'(beat_addr[0]), 32'h10);
      check_eq("beat0_data", 32'(beat_data[0]), 32'hABCD);
      check_eq("beat1_addr", 32'(beat_addr[1]), 32'h11);
      check_eq("beat1_data", 32'(beat_data[1]), 32'h1234);
      check_eq("beat_gap", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
    end
    wb_read("rd_addr", 32'h04, rd);   check_eq("addr_after2", rd, 32'h12);
    wb_write("wr_ctrl", 32'h00, 32'h2);
    check_eq("soc_rst_low", 32'(soc_rst), 32'd0);

    // Fill, stall fifth write, release with one pop
    rom_ready = 1'b0;
    wb_write("wr_ctrl", 32'h00, 32'h1);
    for (int i = 1; i <= 4; i++) wb_write("wr_fill", 32'h08, 32'(i * 32'h1111));
    wb_read("rd_stat", 32'h0C, rd);   check_eq("status_full", rd, 32'h241);
    wb_write("wr_ctrl", 32'h00, 32'h3);
    cycles(1);
    check_eq("head_valid", 32'(rom_valid), 32'd1);
    check_eq("head_addr", 32'(rom_addr), 32'h12);
    check_eq("head_data", 32'(rom_data), 32'h1111);
    done5 = 0;
    ack5 = -1;
    pop_cyc = 0;
    fork
      begin
        wb_xfer("wr_d5", 1'b1, Base + 32'h08, 32'h5555, rd, ack5);
        done5 = 1;
      end
      begin
        cycles(5);
        check_eq("stall_no_ack", 32'(done5), 32'd0);
        rom_ready = 1'b1;
        cycles(1);
        pop_cyc = cyc_cnt;
        rom_ready = 1'b0;
      end
    join
    check_eq("ack5_timing", 32'(ack5), 32'(pop_cyc + 1));

    // Stable outputs while stalled, then flush waits for ready
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (!rom_valid || rom_addr != 15'h13 || rom_data != 16'h2222) bad++;
    end
    check_eq("hold_stable", 32'(bad), 32'd0);
    check_eq("hold_addr", 32'(rom_addr), 32'h13);
    wb_write("wr_flush", 32'h00, 32'h7);
    wb_read("rd_stat", 32'h0C, rd);   check_eq("flush_pending", rd, 32'h241);
    wb_read("rd_ctrl", 32'h00, rd);   check_eq("ctrl_flush_rd0", rd, 32'h3);
    rom_ready = 1'b1;
    cycles(1);
    rom_ready = 1'b0;
    cycles(1);
    wb_read("rd_stat", 32'h0C, rd);   check_eq("flush_done", rd, 32'h0);
    check_eq("flush_valid", 32'(rom_valid), 32'd0);

    // Address wrap and sticky flag
    wb_write("wr_ctrl", 32'h00, 32'h1);
    wb_write("wr_addr", 32'h04, 32'h7FFF);
    wb_write("wr_dw", 32'h08, 32'hBEEF);
    wb_read("rd_addr", 32'h04, rd);   check_eq("addr_wrap", rd, 32'h0);
    wb_read("rd_stat", 32'h0C, rd);   check_eq("status_wrap", rd, 32'h111);
    wb_write("wr_w1c", 32'h0C, 32'h100);
    wb_read("rd_stat", 32'h0C, rd);   check_eq("wrap_cleared", rd, 32'h011);
    wb_write("wr_flush", 32'h00, 32'h5);
    wb_read("rd_stat", 32'h0C, rd);   check_eq("idle_flush", rd, 32'h0);

    // Checksum window
    do_reset();
`ifdef ROM_LOADER_CHECKSUM_EN
    wb_write("wr_d", 32'h08, 32'hFFFF);
    wb_write("wr_d", 32'h08, 32'h0002);
    rom_ready = 1'b1;
    wb_write("wr_ctrl", 32'h00, 32'h3);
    cycles(4);
    rom_ready = 1'b0;
    wb_read("rd_csum", 32'h10, rd);   check_eq("csum", rd, 32'h1);
    wb_write("wr_csum", 32'h10, 32'h0);
    wb_read("rd_csum", 32'h10, rd);   check_eq("csum_clr", rd, 32'h0);
`else
    wb_read("rd_csum", 32'h10, rd);   check_eq("csum_unmapped", rd, 32'h0);
`endif

    // Reset aborts an in-flight beat
    wb_write("wr_d", 32'h08, 32'h7777);
    wb_write("wr_ctrl", 32'h00, 32'h3);
    cycles(1);
    check_eq("pre_rst_valid", 32'(rom_valid), 32'd1);
    rst = 1'b1;
    cycles(1);
    check_eq("rst_abort_valid", 32'(rom_valid), 32'd0);
    check_eq("rst_abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
